// File: rtl/isa_pkg.sv
// isa_pkg: shared encodings for the byte-stream instruction executor.
//   - opcode / modifier values of the 16-bit instruction [op:2][mod:6][src:4][dst:4]
//   - control FSM state encoding
//   - bit positions inside the sticky fault vector
package isa_pkg;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_M = 2'b01;

  // R-family modifiers
  localparam logic [5:0] MOD_MOV  = 6'b000000;
  localparam logic [5:0] MOD_ADD  = 6'b000001;
  localparam logic [5:0] MOD_SUB  = 6'b000010;
  localparam logic [5:0] MOD_AND  = 6'b000011;
  localparam logic [5:0] MOD_OR   = 6'b000100;
  localparam logic [5:0] MOD_XOR  = 6'b000101;
  localparam logic [5:0] MOD_ADDI = 6'b010000;
  localparam logic [5:0] MOD_MOVI = 6'b010001;

  // M-family modifiers
  localparam logic [5:0] MOD_PUSH = 6'b000010;
  localparam logic [5:0] MOD_POP  = 6'b000011;

  // Fault vector layout: {frame_err, underflow, overflow}
  localparam int unsigned FAULT_OVF = 0;
  localparam int unsigned FAULT_UDF = 1;
  localparam int unsigned FAULT_FRM = 2;

  typedef enum logic [1:0] {
    StFetchHi,
    StFetchLo,
    StPushWait,
    StPopWait
  } state_e;

endpackage

// File: rtl/isa_alu.sv
// isa_alu: combinational R-family datapath.
// Ports:
//   i_mod    - 6-bit modifier field
//   i_a      - current destination register value
//   i_b      - current source register value
//   i_imm    - src field, used zero-extended by ADDI / MOVI
//   o_result - value to write into the destination register
//   o_we     - 1 when i_mod is a defined R-family operation
module isa_alu
  import isa_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [5:0]        i_mod,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_we
);

  logic [DATA_W-1:0] w_imm;
  assign w_imm = {{(DATA_W-4){1'b0}}, i_imm};

  always_comb begin
    o_result = '0;
    o_we     = 1'b1;
    case (i_mod)
      MOD_MOV:  o_result = i_b;
      MOD_ADD:  o_result = i_a + i_b;
      MOD_SUB:  o_result = i_a - i_b;
      MOD_AND:  o_result = i_a & i_b;
      MOD_OR:   o_result = i_a | i_b;
      MOD_XOR:  o_result = i_a ^ i_b;
      MOD_ADDI: o_result = i_a + w_imm;
      MOD_MOVI: o_result = w_imm;
      default:  o_we = 1'b0;
    endcase
  end

endmodule

// File: rtl/isa_exec_core.sv
// isa_exec_core: assembles 16-bit instructions from a byte stream and executes them on a
// 16-entry register file, spilling PUSH/POP traffic to SDRAM via single-word bursts.
// Optional build macro: ISA_BYTE_TIMEOUT_EN enables the inter-byte timeout (frame_err).
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   byte_data/valid/ready      - incoming instruction bytes (high byte first)
//   wr_burst_*                 - SDRAM write request, data, length (1), byte address
//   rd_burst_*                 - SDRAM read request, length (1), address, returned data
//   disp_value                 - contents of register DISP_REG
//   sp_out                     - stack pointer (byte address of next free slot)
//   fault                      - sticky {frame_err, underflow, overflow}
//   retired                    - wrapping count of completed instructions
module isa_exec_core
  import isa_pkg::*;
#(
  parameter int unsigned        DATA_W      = 16,
  parameter int unsigned        ADDR_W      = 24,
  parameter logic [ADDR_W-1:0]  STACK_BASE  = 24'h900010,
  parameter int unsigned        STACK_DEPTH = 64,
  parameter int unsigned        DISP_REG    = 3,
  parameter int unsigned        TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_burst_req,
  output logic [DATA_W-1:0] wr_burst_data,
  output logic [9:0]        wr_burst_len,
  output logic [ADDR_W-1:0] wr_burst_addr,
  input  logic              wr_burst_data_req,
  input  logic              wr_burst_finish,
  output logic              rd_burst_req,
  output logic [9:0]        rd_burst_len,
  output logic [ADDR_W-1:0] rd_burst_addr,
  input  logic [DATA_W-1:0] rd_burst_data,
  input  logic              rd_burst_data_valid,
  input  logic              rd_burst_finish,
  output logic [DATA_W-1:0] disp_value,
  output logic [ADDR_W-1:0] sp_out,
  output logic [2:0]        fault,
  output logic [15:0]       retired
);

  localparam logic [ADDR_W-1:0] SP_STEP   = ADDR_W'(DATA_W / 8);
  // sp value at which the stack holds STACK_DEPTH words
  localparam logic [ADDR_W-1:0] STACK_TOP = STACK_BASE + ADDR_W'(STACK_DEPTH * (DATA_W / 8));
  localparam logic [3:0]        DISP_IDX  = 4'(DISP_REG);

  // Write data is held in r_wr_data for the whole burst, so the data request strobe
  // carries no extra information for a single-word burst.
  logic w_unused_data_req;
  assign w_unused_data_req = wr_burst_data_req;

  state_e            r_state, w_state_d;
  logic [7:0]        r_hi, w_hi_d;
  logic [DATA_W-1:0] r_regs [16];
  logic [ADDR_W-1:0] r_sp, w_sp_d;
  logic [2:0]        r_fault, w_fault_d;
  logic [15:0]       r_retired, w_retired_d;
  logic              r_wr_req, w_wr_req_d;
  logic              r_rd_req, w_rd_req_d;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_d;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_d;
  logic [DATA_W-1:0] r_wr_data, w_wr_data_d;
  logic [3:0]        r_pop_dst, w_pop_dst_d;
  logic              r_byte_ready;

  logic              w_rf_we;
  logic [3:0]        w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;

  // Decode fields: high byte is latched, low byte is the one being accepted now.
  logic              w_acc;
  logic [1:0]        w_op;
  logic [5:0]        w_mod;
  logic [3:0]        w_src;
  logic [3:0]        w_dst;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_we;
  logic              w_expire;

  assign w_acc = byte_valid & r_byte_ready;
  assign w_op  = r_hi[7:6];
  assign w_mod = r_hi[5:0];
  assign w_src = byte_data[7:4];
  assign w_dst = byte_data[3:0];

  isa_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_mod    (w_mod),
    .i_a      (r_regs[w_dst]),
    .i_b      (r_regs[w_src]),
    .i_imm    (w_src),
    .o_result (w_alu_res),
    .o_we     (w_alu_we)
  );

`ifdef ISA_BYTE_TIMEOUT_EN
  logic [31:0] r_tcnt;

  // Counts cycles spent in FETCH_LO; zero on the first cycle after entry.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state != StFetchLo) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 32'd1;
    end
  end

  assign w_expire = (r_state == StFetchLo) && (r_tcnt == TIMEOUT_CYC - 1);
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_hi_d      = r_hi;
    w_sp_d      = r_sp;
    w_fault_d   = r_fault;
    w_retired_d = r_retired;
    w_wr_req_d  = r_wr_req;
    w_rd_req_d  = r_rd_req;
    w_wr_addr_d = r_wr_addr;
    w_rd_addr_d = r_rd_addr;
    w_wr_data_d = r_wr_data;
    w_pop_dst_d = r_pop_dst;
    w_rf_we     = 1'b0;
    w_rf_waddr  = w_dst;
    w_rf_wdata  = w_alu_res;

    case (r_state)
      StFetchHi: begin
        if (w_acc) begin
          w_hi_d    = byte_data;
          w_state_d = StFetchLo;
        end
      end

      StFetchLo: begin
        if (w_acc) begin
          // Every completed instruction retires here, including faults and no-ops.
          w_retired_d = r_retired + 16'd1;
          w_state_d   = StFetchHi;
          if (w_op == OP_R) begin
            w_rf_we = w_alu_we;
          end else if (w_op == OP_M && w_mod == MOD_PUSH) begin
            if (r_sp == STACK_TOP) begin
              w_fault_d[FAULT_OVF] = 1'b1;
            end else begin
              w_wr_addr_d = r_sp;
              w_wr_data_d = r_regs[w_dst];
              w_wr_req_d  = 1'b1;
              w_sp_d      = r_sp + SP_STEP;
              w_state_d   = StPushWait;
            end
          end else if (w_op == OP_M && w_mod == MOD_POP) begin
            if (r_sp == STACK_BASE) begin
              w_fault_d[FAULT_UDF] = 1'b1;
            end else begin
              w_sp_d      = r_sp - SP_STEP;
              w_rd_addr_d = r_sp - SP_STEP;
              w_rd_req_d  = 1'b1;
              w_pop_dst_d = w_dst;
              w_state_d   = StPopWait;
            end
          end
        end else if (w_expire) begin
          // A byte arriving in the expiry cycle wins over the timeout.
          w_fault_d[FAULT_FRM] = 1'b1;
          w_state_d            = StFetchHi;
        end
      end

      StPushWait: begin
        if (wr_burst_finish) begin
          w_wr_req_d = 1'b0;
          w_state_d  = StFetchHi;
        end
      end

      StPopWait: begin
        if (rd_burst_data_valid) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = r_pop_dst;
          w_rf_wdata = rd_burst_data;
        end
        if (rd_burst_finish) begin
          w_rd_req_d = 1'b0;
          w_state_d  = StFetchHi;
        end
      end

      default: w_state_d = StFetchHi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StFetchHi;
      r_hi         <= '0;
      r_sp         <= STACK_BASE;
      r_fault      <= '0;
      r_retired    <= '0;
      r_wr_req     <= 1'b0;
      r_rd_req     <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_wr_data    <= '0;
      r_pop_dst    <= '0;
      r_byte_ready <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state      <= w_state_d;
      r_hi         <= w_hi_d;
      r_sp         <= w_sp_d;
      r_fault      <= w_fault_d;
      r_retired    <= w_retired_d;
      r_wr_req     <= w_wr_req_d;
      r_rd_req     <= w_rd_req_d;
      r_wr_addr    <= w_wr_addr_d;
      r_rd_addr    <= w_rd_addr_d;
      r_wr_data    <= w_wr_data_d;
      r_pop_dst    <= w_pop_dst_d;
      // Registered so it is already high on the first cycle of a fetch state.
      r_byte_ready <= (w_state_d == StFetchHi) || (w_state_d == StFetchLo);
      if (w_rf_we) begin
        r_regs[w_rf_waddr] <= w_rf_wdata;
      end
    end
  end

  assign byte_ready    = r_byte_ready;
  assign wr_burst_req  = r_wr_req;
  assign wr_burst_data = r_wr_data;
  assign wr_burst_len  = 10'd1;
  assign wr_burst_addr = r_wr_addr;
  assign rd_burst_req  = r_rd_req;
  assign rd_burst_len  = 10'd1;
  assign rd_burst_addr = r_rd_addr;
  assign disp_value    = r_regs[DISP_IDX];
  assign sp_out        = r_sp;
  assign fault         = r_fault;
  assign retired       = r_retired;

endmodule

// File: tb/tb_isa_exec_core.sv
module tb_isa_exec_core;

  localparam logic [23:0] BASE = 24'h900010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_burst_req;
  logic [15:0] wr_burst_data;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic        wr_burst_finish;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [23:0] rd_burst_addr;
  logic [15:0] rd_burst_data;
  logic        rd_burst_data_valid;
  logic        rd_burst_finish;
  logic [15:0] disp_value;
  logic [23:0] sp_out;
  logic [2:0]  fault;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_retired;

  // Scoreboard queues: expected pushed at stimulus time, observed pushed by the memory model.
  logic [23:0] exp_wr_addr_q[$];
  logic [15:0] exp_wr_data_q[$];
  logic [23:0] exp_rd_addr_q[$];
  logic [23:0] obs_wr_addr_q[$];
  logic [15:0] obs_wr_data_q[$];
  logic [23:0] obs_rd_addr_q[$];
  logic [15:0] mem [logic [23:0]];

  int wr_cnt = 0;
  int rd_cnt = 0;
  int overlap_cyc = 0;
  int rd_req_cyc = 0;

  isa_exec_core #(
    .DATA_W      (16),
    .ADDR_W      (24),
    .STACK_BASE  (24'h900010),
    .STACK_DEPTH (2),
    .DISP_REG    (3),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .byte_data           (byte_data),
    .byte_valid          (byte_valid),
    .byte_ready          (byte_ready),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_finish     (wr_burst_finish),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_finish     (rd_burst_finish),
    .disp_value          (disp_value),
    .sp_out              (sp_out),
    .fault               (fault),
    .retired             (retired)
  );

  always #5 clk = ~clk;

  // SDRAM model, driven on the falling edge: one-word bursts with a few cycles of latency.
  initial begin
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data       = '0;
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
  end

  always @(negedge clk) begin
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
    if (wr_burst_req && rd_burst_req) overlap_cyc++;
    if (rd_burst_req) rd_req_cyc++;
    if (!rst_n || !wr_burst_req) begin
      wr_cnt = 0;
    end else begin
      wr_cnt++;
      if (wr_cnt == 2) wr_burst_data_req = 1'b1;
      if (wr_cnt == 3) begin
        mem[wr_burst_addr] = wr_burst_data;
        obs_wr_addr_q.push_back(wr_burst_addr);
        obs_wr_data_q.push_back(wr_burst_data);
      end
      if (wr_cnt == 4) wr_burst_finish = 1'b1;
    end
    if (!rst_n || !rd_burst_req) begin
      rd_cnt = 0;
    end else begin
      rd_cnt++;
      if (rd_cnt == 3) begin
        obs_rd_addr_q.push_back(rd_burst_addr);
        rd_burst_data       = mem.exists(rd_burst_addr) ? mem[rd_burst_addr] : 16'h0000;
        rd_burst_data_valid = 1'b1;
        rd_burst_finish     = 1'b1;
      end
    end
  end

  // Presents one byte and returns 1 ns after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte_ready got %b required 1 for byte %h", byte_ready, b);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    send_byte(lo);
    exp_retired++;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: byte_ready got %b required 1 after burst", byte_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_retired = 16'd0;
    overlap_cyc = 0;
    rd_req_cyc  = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 10;
    if (disp_value !== 16'h0) begin errors++; $display("FAIL rst_disp: got %h required 0000", disp_value); end
    if (sp_out !== BASE) begin errors++; $display("FAIL rst_sp: got %h required %h", sp_out, BASE); end
    if (fault !== 3'b000) begin errors++; $display("FAIL rst_fault: got %b required 000", fault); end
    if (retired !== 16'h0) begin errors++; $display("FAIL rst_retired: got %h required 0000", retired); end
    if (wr_burst_req !== 1'b0) begin errors++; $display("FAIL rst_wr_req: got %b required 0", wr_burst_req); end
    if (rd_burst_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req: got %b required 0", rd_burst_req); end
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", byte_ready); end
    if (wr_burst_addr !== 24'h0 || rd_burst_addr !== 24'h0) begin
      errors++; $display("FAIL rst_addr: got wr %h rd %h required 0", wr_burst_addr, rd_burst_addr);
    end
    if (wr_burst_data !== 16'h0) begin errors++; $display("FAIL rst_wdata: got %h required 0000", wr_burst_data); end
    if (wr_burst_len !== 10'd1 || rd_burst_len !== 10'd1) begin
      errors++; $display("FAIL burst_len: got wr %0d rd %0d required 1", wr_burst_len, rd_burst_len);
    end
    release_reset();
  endtask

  // {hi, lo, expected r3 afterwards}; r1/r2 evolve as noted.
  task automatic test_alu();
    logic [39:0] tbl [17];
    tbl[0]  = {8'h11, 8'h53, 16'h0005, 8'h0};  // MOVI r3,5
    tbl[1]  = {8'h01, 8'h33, 16'h000A, 8'h0};  // ADD r3,r3
    tbl[2]  = {8'h11, 8'h71, 16'h000A, 8'h0};  // MOVI r1,7
    tbl[3]  = {8'h02, 8'h13, 16'h0003, 8'h0};  // SUB r3,r1
    tbl[4]  = {8'h05, 8'h13, 16'h0004, 8'h0};  // XOR r3,r1
    tbl[5]  = {8'h04, 8'h13, 16'h0007, 8'h0};  // OR r3,r1
    tbl[6]  = {8'h02, 8'h13, 16'h0000, 8'h0};  // SUB r3,r1
    tbl[7]  = {8'h02, 8'h13, 16'hFFF9, 8'h0};  // SUB wraps
    tbl[8]  = {8'h10, 8'hF3, 16'h0008, 8'h0};  // ADDI r3,15 wraps
    tbl[9]  = {8'h11, 8'hC2, 16'h0008, 8'h0};  // MOVI r2,12
    tbl[10] = {8'h00, 8'h13, 16'h0007, 8'h0};  // MOV r3,r1
    tbl[11] = {8'h03, 8'h23, 16'h0004, 8'h0};  // AND r3,r2
    tbl[12] = {8'h3F, 8'h13, 16'h0004, 8'h0};  // unknown R mod
    tbl[13] = {8'h80, 8'h13, 16'h0004, 8'h0};  // op 10
    tbl[14] = {8'hC1, 8'h33, 16'h0004, 8'h0};  // op 11
    tbl[15] = {8'h40, 8'h33, 16'h0004, 8'h0};  // unknown M mod
    tbl[16] = {8'h01, 8'h33, 16'h0008, 8'h0};  // ADD r3,r3
    for (int i = 0; i < 17; i++) begin
      send_instr(tbl[i][39:32], tbl[i][31:24]);
      checks += 2;
      if (disp_value !== tbl[i][23:8]) begin
        errors++; $display("FAIL alu_%0d: disp got %h required %h", i, disp_value, tbl[i][23:8]);
      end
      if (retired !== exp_retired) begin
        errors++; $display("FAIL alu_retired_%0d: got %0d required %0d", i, retired, exp_retired);
      end
    end
  endtask

  task automatic test_underflow();
    send_instr(8'h43, 8'h03);  // POP r3 on empty stack
    repeat (8) @(negedge clk);
    checks += 5;
    if (fault !== 3'b010) begin errors++; $display("FAIL udf_fault: got %b required 010", fault); end
    if (rd_req_cyc !== 0) begin errors++; $display("FAIL udf_rd_req: got %0d cycles required 0", rd_req_cyc); end
    if (disp_value !== 16'h0008) begin errors++; $display("FAIL udf_r3: got %h required 0008", disp_value); end
    if (sp_out !== BASE) begin errors++; $display("FAIL udf_sp: got %h required %h", sp_out, BASE); end
    if (retired !== exp_retired) begin errors++; $display("FAIL udf_retired: got %0d required %0d", retired, exp_retired); end
  endtask

  task automatic test_push_pop();
    send_instr(8'h11, 8'h71);  // MOVI r1,7
    exp_wr_addr_q.push_back(BASE);
    exp_wr_data_q.push_back(16'h0007);
    send_instr(8'h42, 8'h01);  // PUSH r1
    checks++;
    if (sp_out !== BASE + 24'd2) begin errors++; $display("FAIL push_sp: got %h required %h", sp_out, BASE + 24'd2); end
    wait_ready();
    exp_rd_addr_q.push_back(BASE);
    send_instr(8'h43, 8'h02);  // POP r2
    wait_ready();
    send_instr(8'h00, 8'h23);  // MOV r3,r2
    checks += 4;
    if (disp_value !== 16'h0007) begin errors++; $display("FAIL pop_r2: got %h required 0007", disp_value); end
    if (sp_out !== BASE) begin errors++; $display("FAIL pop_sp: got %h required %h", sp_out, BASE); end
    if (fault !== 3'b000) begin errors++; $display("FAIL pp_fault: got %b required 000", fault); end
    if (retired !== exp_retired) begin errors++; $display("FAIL pp_retired: got %0d required %0d", retired, exp_retired); end
    while (exp_wr_addr_q.size() > 0) begin
      logic [23:0] ea;
      logic [15:0] ed;
      ea = exp_wr_addr_q.pop_front();
      ed = exp_wr_data_q.pop_front();
      checks++;
      if (obs_wr_addr_q.size() == 0) begin
        errors++; $display("FAIL pp_wr: got no write required addr %h data %h", ea, ed);
      end else begin
        logic [23:0] oa;
        logic [15:0] od;
        oa = obs_wr_addr_q.pop_front();
        od = obs_wr_data_q.pop_front();
        if (oa !== ea || od !== ed) begin
          errors++; $display("FAIL pp_wr: got %h/%h required %h/%h", oa, od, ea, ed);
        end
      end
    end
    while (exp_rd_addr_q.size() > 0) begin
      logic [23:0] ea;
      ea = exp_rd_addr_q.pop_front();
      checks++;
      if (obs_rd_addr_q.size() == 0) begin
        errors++; $display("FAIL pp_rd: got no read required addr %h", ea);
      end else if (obs_rd_addr_q[0] !== ea) begin
        errors++; $display("FAIL pp_rd: got %h required %h", obs_rd_addr_q[0], ea);
        void'(obs_rd_addr_q.pop_front());
      end else begin
        void'(obs_rd_addr_q.pop_front());
      end
    end
  endtask

  task automatic test_overflow();
    send_instr(8'h11, 8'h13);  // MOVI r3,1
    exp_wr_addr_q.push_back(BASE);
    exp_wr_data_q.push_back(16'h0001);
    send_instr(8'h42, 8'h03);  // PUSH r3
    wait_ready();
    send_instr(8'h11, 8'h23);  // MOVI r3,2
    exp_wr_addr_q.push_back(BASE + 24'd2);
    exp_wr_data_q.push_back(16'h0002);
    send_instr(8'h42, 8'h03);  // PUSH r3
    wait_ready();
    send_instr(8'h42, 8'h03);  // PUSH r3 with stack full
    repeat (10) @(negedge clk);
    checks += 3;
    if (fault !== 3'b001) begin errors++; $display("FAIL ovf_fault: got %b required 001", fault); end
    if (sp_out !== BASE + 24'd4) begin errors++; $display("FAIL ovf_sp: got %h required %h", sp_out, BASE + 24'd4); end
    if (obs_wr_addr_q.size() !== exp_wr_addr_q.size()) begin
      errors++; $display("FAIL ovf_wr_count: got %0d required %0d", obs_wr_addr_q.size(), exp_wr_addr_q.size());
    end
    while (exp_wr_addr_q.size() > 0 && obs_wr_addr_q.size() > 0) begin
      logic [23:0] ea, oa;
      logic [15:0] ed, od;
      ea = exp_wr_addr_q.pop_front();
      ed = exp_wr_data_q.pop_front();
      oa = obs_wr_addr_q.pop_front();
      od = obs_wr_data_q.pop_front();
      checks++;
      if (oa !== ea || od !== ed) begin
        errors++; $display("FAIL ovf_wr: got %h/%h required %h/%h", oa, od, ea, ed);
      end
    end
    exp_wr_addr_q.delete();
    exp_wr_data_q.delete();
    obs_wr_addr_q.delete();
    obs_wr_data_q.delete();
    send_instr(8'h43, 8'h03);  // POP r3 -> 2
    wait_ready();
    checks++;
    if (disp_value !== 16'h0002) begin errors++; $display("FAIL lifo_0: got %h required 0002", disp_value); end
    send_instr(8'h43, 8'h03);  // POP r3 -> 1
    wait_ready();
    checks += 4;
    if (disp_value !== 16'h0001) begin errors++; $display("FAIL lifo_1: got %h required 0001", disp_value); end
    if (sp_out !== BASE) begin errors++; $display("FAIL lifo_sp: got %h required %h", sp_out, BASE); end
    if (retired !== exp_retired) begin errors++; $display("FAIL ovf_retired: got %0d required %0d", retired, exp_retired); end
    if (overlap_cyc !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d cycles required 0", overlap_cyc); end
    obs_rd_addr_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    send_instr(8'h11, 8'h53);  // MOVI r3,5
    send_instr(8'h42, 8'h03);  // PUSH r3
    checks++;
    if (wr_burst_req !== 1'b1) begin errors++; $display("FAIL mid_req_on: got %b required 1", wr_burst_req); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_retired = 16'd0;
    checks += 4;
    if (wr_burst_req !== 1'b0) begin errors++; $display("FAIL mid_req_off: got %b required 0", wr_burst_req); end
    if (sp_out !== BASE) begin errors++; $display("FAIL mid_sp: got %h required %h", sp_out, BASE); end
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b required 0", byte_ready); end
    if (obs_wr_addr_q.size() !== 0) begin
      errors++; $display("FAIL mid_no_write: got %0d writes required 0", obs_wr_addr_q.size());
    end
    release_reset();
    send_instr(8'h11, 8'h93);  // MOVI r3,9 works from FETCH_HI
    checks += 2;
    if (disp_value !== 16'h0009) begin errors++; $display("FAIL mid_resume: got %h required 0009", disp_value); end
    if (retired !== 16'd1) begin errors++; $display("FAIL mid_retired: got %0d required 1", retired); end
  endtask

  task automatic test_byte_timeout();
    do_reset();
    release_reset();
    send_byte(8'h11);
    repeat (150) @(negedge clk);
`ifdef ISA_BYTE_TIMEOUT_EN
    checks++;
    if (fault !== 3'b100) begin errors++; $display("FAIL tmo_frame: got %b required 100", fault); end
    send_instr(8'h11, 8'h53);
`else
    checks++;
    if (fault !== 3'b000) begin errors++; $display("FAIL tmo_frame: got %b required 000", fault); end
    send_byte(8'h53);
    exp_retired++;
`endif
    checks += 2;
    if (disp_value !== 16'h0005) begin errors++; $display("FAIL tmo_r3: got %h required 0005", disp_value); end
    if (retired !== exp_retired) begin errors++; $display("FAIL tmo_retired: got %0d required %0d", retired, exp_retired); end
  endtask

  initial begin
    rst_n       = 1'b0;
    byte_data   = 8'h00;
    byte_valid  = 1'b0;
    exp_retired = 16'd0;
    test_reset();
    test_alu();
    test_underflow();
    do_reset();
    release_reset();
    test_push_pop();
    test_overflow();
    test_reset_mid_burst();
    test_byte_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
